// File: rtl/led_sequencer_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : led_sequencer_master
// Purpose  : AXI4-Lite write master that animates the LED register on a timer.
//            Optional macro LED_SEQ_READBACK_EN adds a verify read after each write.
// Revision : 1.0  initial release
// ============================================================================
module led_sequencer_master #(
   parameter int AW       = 7,
   parameter int LED_ADDR = 0,
   parameter int PERIOD_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [15:0]         static_pattern,
   input  logic [PERIOD_W-1:0] period,
   output logic                busy,
   output logic [15:0]         pattern,
   output logic [7:0]          err_count,
   output logic                overrun,
`ifdef LED_SEQ_READBACK_EN
   output logic [7:0]          mismatch_count,
   output logic [AW-1:0]       M_AXI_ARADDR,
   output logic                M_AXI_ARVALID,
   output logic [2:0]          M_AXI_ARPROT,
   input  logic                M_AXI_ARREADY,
   input  logic [31:0]         M_AXI_RDATA,
   input  logic                M_AXI_RVALID,
   input  logic [1:0]          M_AXI_RRESP,
   output logic                M_AXI_RREADY,
`endif
   output logic [AW-1:0]       M_AXI_AWADDR,
   output logic                M_AXI_AWVALID,
   output logic [2:0]          M_AXI_AWPROT,
   input  logic                M_AXI_AWREADY,
   output logic [31:0]         M_AXI_WDATA,
   output logic [3:0]          M_AXI_WSTRB,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY
);

   localparam logic [AW-1:0] c_led_addr = AW'(LED_ADDR);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_RESP  = 3'd2,
      S_RADDR = 3'd3,
      S_RDATA = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PERIOD_W-1:0] r_timer;
   logic [15:0]         r_pattern;
   logic                r_dir;        // 0 = moving left, 1 = moving right
   logic [15:0]         r_wdata;
   logic                r_wdir;
   logic [7:0]          r_err;
   logic                r_overrun;
   logic                r_awvalid;
   logic                r_wvalid;
   logic                r_bready;

   logic                w_tick;
   logic                w_onehot;
   logic [15:0]         w_cand;
   logic                w_cand_dir;
   logic                w_awvalid_nxt;
   logic                w_wvalid_nxt;
   logic                w_bready_nxt;
   logic                w_load;
   logic                w_commit;
   logic                w_err_inc;

`ifdef LED_SEQ_READBACK_EN
   logic                r_arvalid;
   logic                r_rready;
   logic [7:0]          r_mismatch;
   logic                w_arvalid_nxt;
   logic                w_rready_nxt;
   logic                w_mis_inc;
   logic                w_unused_rdata_hi;

   assign w_unused_rdata_hi = ^M_AXI_RDATA[31:16];
   assign M_AXI_ARADDR      = c_led_addr;
   assign M_AXI_ARVALID     = r_arvalid;
   assign M_AXI_ARPROT      = 3'b000;
   assign M_AXI_RREADY      = r_rready;
   assign mismatch_count    = r_mismatch;
`endif

   assign w_tick        = enable && (r_timer == period);
   assign busy          = (r_state != S_IDLE);
   assign pattern       = r_pattern;
   assign err_count     = r_err;
   assign overrun       = r_overrun;
   assign M_AXI_AWADDR  = c_led_addr;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_WDATA   = {16'h0000, r_wdata};
   assign M_AXI_WSTRB   = 4'b1111;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;

   // Candidate pattern and bounce direction, committed only on an OKAY response
   always_comb begin
      w_onehot   = (r_pattern != 16'h0000) && ((r_pattern & (r_pattern - 16'd1)) == 16'h0000);
      w_cand     = r_pattern;
      w_cand_dir = r_dir;
      case (mode)
         2'd0: w_cand = r_pattern + 16'd1;
         2'd1: w_cand = (r_pattern == 16'h0000) ? 16'h0001 : {r_pattern[14:0], r_pattern[15]};
         2'd2: begin
            if (!w_onehot) begin
               w_cand     = 16'h0001;
               w_cand_dir = 1'b0;
            end else if (r_dir == 1'b0) begin
               if (r_pattern[15]) begin
                  w_cand     = r_pattern >> 1;
                  w_cand_dir = 1'b1;
               end else begin
                  w_cand     = r_pattern << 1;
               end
            end else begin
               if (r_pattern[0]) begin
                  w_cand     = r_pattern << 1;
                  w_cand_dir = 1'b0;
               end else begin
                  w_cand     = r_pattern >> 1;
               end
            end
         end
         default: w_cand = static_pattern;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_awvalid_nxt = r_awvalid;
      w_wvalid_nxt  = r_wvalid;
      w_bready_nxt  = r_bready;
      w_load        = 1'b0;
      w_commit      = 1'b0;
      w_err_inc     = 1'b0;
`ifdef LED_SEQ_READBACK_EN
      w_arvalid_nxt = r_arvalid;
      w_rready_nxt  = r_rready;
      w_mis_inc     = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_tick) begin
               w_load        = 1'b1;
               w_awvalid_nxt = 1'b1;
               w_wvalid_nxt  = 1'b1;
               w_state_nxt   = S_ADDR;
            end
         end
         S_ADDR: begin
            // AW and W retire independently; each channel is done once its valid is low
            if (r_awvalid && M_AXI_AWREADY) w_awvalid_nxt = 1'b0;
            if (r_wvalid && M_AXI_WREADY)   w_wvalid_nxt  = 1'b0;
            if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) begin
               w_bready_nxt = 1'b1;
               w_state_nxt  = S_RESP;
            end
         end
         S_RESP: begin
            if (M_AXI_BVALID && r_bready) begin
               w_bready_nxt = 1'b0;
               if (M_AXI_BRESP == 2'b00) begin
                  w_commit = 1'b1;
`ifdef LED_SEQ_READBACK_EN
                  w_arvalid_nxt = 1'b1;
                  w_state_nxt   = S_RADDR;
`else
                  w_state_nxt   = S_IDLE;
`endif
               end else begin
                  w_err_inc   = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
`ifdef LED_SEQ_READBACK_EN
         S_RADDR: begin
            if (r_arvalid && M_AXI_ARREADY) begin
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
               w_state_nxt   = S_RDATA;
            end
         end
         S_RDATA: begin
            if (M_AXI_RVALID && r_rready) begin
               w_rready_nxt = 1'b0;
               w_mis_inc    = (M_AXI_RDATA[15:0] != r_wdata) || (M_AXI_RRESP != 2'b00);
               w_state_nxt  = S_IDLE;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timer   <= '0;
         r_pattern <= 16'h0000;
         r_dir     <= 1'b0;
         r_wdata   <= 16'h0000;
         r_wdir    <= 1'b0;
         r_err     <= 8'd0;
         r_overrun <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
      end else begin
         // Wrapping on >= also recovers when period is lowered below the count
         if (!enable || (r_timer >= period)) r_timer <= '0;
         else                                r_timer <= r_timer + PERIOD_W'(1);
         r_awvalid <= w_awvalid_nxt;
         r_wvalid  <= w_wvalid_nxt;
         r_bready  <= w_bready_nxt;
         if (w_load) begin
            r_wdata <= w_cand;
            r_wdir  <= w_cand_dir;
         end
         if (w_commit) begin
            r_pattern <= r_wdata;
            r_dir     <= r_wdir;
         end
         if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
         if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      end
   end

`ifdef LED_SEQ_READBACK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_mismatch <= 8'd0;
      end else begin
         r_arvalid <= w_arvalid_nxt;
         r_rready  <= w_rready_nxt;
         if (w_mis_inc && (r_mismatch != 8'hFF)) r_mismatch <= r_mismatch + 8'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_led_sequencer_master
// Purpose  : Directed bench with an AXI4-Lite slave model and write scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_sequencer_master;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, enable;
   logic [1:0]  mode;
   logic [15:0] static_pattern;
   logic [31:0] period;
   logic        busy, overrun;
   logic [15:0] pattern;
   logic [7:0]  err_count;
   logic [6:0]  AWADDR;
   logic [2:0]  AWPROT;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [1:0]  BRESP;

   int          aw_hold, w_hold, b_hold, aw_wait, w_wait, b_wait;
   logic [1:0]  bresp_cfg;
   logic        aw_got, w_got, aw_hs, w_hs;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          b_cnt = 0;
   int          n8000 = 0;
   int          aw_times[$];
   logic [15:0] exp_q[$];
   logic [15:0] exp_pat;

`ifdef LED_SEQ_READBACK_EN
   logic [7:0]  mismatch_count;
   logic [6:0]  ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID, RVALID, RREADY, rd_bad;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic [15:0] last_w;
   assign ARREADY = 1'b1;
   assign RRESP   = 2'b00;
`endif

   led_sequencer_master dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .static_pattern(static_pattern), .period(period),
      .busy(busy), .pattern(pattern), .err_count(err_count), .overrun(overrun),
`ifdef LED_SEQ_READBACK_EN
      .mismatch_count(mismatch_count),
      .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARPROT(ARPROT),
      .M_AXI_ARREADY(ARREADY), .M_AXI_RDATA(RDATA), .M_AXI_RVALID(RVALID),
      .M_AXI_RRESP(RRESP), .M_AXI_RREADY(RREADY),
`endif
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWPROT(AWPROT),
      .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
      .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
      .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
   );

   // Slave model: readies held off by a programmable number of cycles
   assign AWREADY = AWVALID && (aw_wait >= aw_hold);
   assign WREADY  = WVALID && (w_wait >= w_hold);
   assign aw_hs   = AWVALID && AWREADY;
   assign w_hs    = WVALID && WREADY;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         aw_wait <= 0; w_wait <= 0; b_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
      end else begin
         aw_wait <= aw_hs ? 0 : (AWVALID ? aw_wait + 1 : aw_wait);
         w_wait  <= w_hs  ? 0 : (WVALID  ? w_wait + 1  : w_wait);
         aw_got  <= aw_got | aw_hs;
         w_got   <= w_got | w_hs;
         if (BVALID) begin
            if (BREADY) BVALID <= 1'b0;
         end else if ((aw_got | aw_hs) && (w_got | w_hs)) begin
            if (b_wait >= b_hold) begin
               BVALID <= 1'b1; BRESP <= bresp_cfg; b_wait <= 0;
               aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
               b_wait <= b_wait + 1;
            end
         end
      end
   end

`ifdef LED_SEQ_READBACK_EN
   always @(posedge clk) begin
      if (reset) begin
         RVALID <= 1'b0; RDATA <= 32'h0; last_w <= 16'h0;
      end else begin
         if (w_hs) last_w <= WDATA[15:0];
         if (ARVALID && ARREADY) begin
            RVALID <= 1'b1;
            RDATA  <= rd_bad ? 32'h0000_1234 : {16'h0000, last_w};
         end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
         end
      end
   end
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every W handshake pops the next expected pattern
   always @(negedge clk) begin
      if (!reset) begin
         if (w_hs) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL wr_extra observed=%h expected=no write", WDATA);
            end
            if (exp_q.size() > 0) check("wdata", WDATA, {16'h0000, exp_q.pop_front()});
            check("wstrb", {28'h0, WSTRB}, 32'hF);
            if (WDATA[15:0] == 16'h8000) n8000 <= n8000 + 1;
         end
         if (aw_hs) begin
            check("awaddr", {25'h0, AWADDR}, 32'h0);
            check("awprot", {29'h0, AWPROT}, 32'h0);
            aw_times.push_back(cyc);
         end
         if (BVALID && BREADY) b_cnt <= b_cnt + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_b(input int target, input int budget);
      int n = 0;
      while (b_cnt < target && n < budget) begin
         step(1);
         n++;
      end
      check("b_wait_done", 32'(b_cnt >= target), 32'h1);
   endtask

   initial begin
      int base, s, n;
      logic flag;
      reset = 1'b1; enable = 1'b0; mode = 2'd0; static_pattern = 16'h0; period = 32'd3;
      aw_hold = 0; w_hold = 0; b_hold = 0; bresp_cfg = 2'b00;
`ifdef LED_SEQ_READBACK_EN
      rd_bad = 1'b0;
`endif
      step(3);
      reset = 1'b0;
      step(1);
      check("rst_awvalid", {31'h0, AWVALID}, 0);
      check("rst_wvalid", {31'h0, WVALID}, 0);
      check("rst_bready", {31'h0, BREADY}, 0);
      check("rst_busy", {31'h0, busy}, 0);
      check("rst_pattern", {16'h0, pattern}, 0);
      check("rst_err", {24'h0, err_count}, 0);
      check("rst_overrun", {31'h0, overrun}, 0);
`ifdef LED_SEQ_READBACK_EN
      check("rst_mismatch", {24'h0, mismatch_count}, 0);
`endif
      exp_pat = 16'h0000;

      // Binary count, one write every period+1 cycles
      base = b_cnt; s = aw_times.size();
      for (int i = 0; i < 3; i++) begin exp_pat = exp_pat + 16'd1; exp_q.push_back(exp_pat); end
      enable = 1'b1;
      wait_b(base + 3, 60);
      enable = 1'b0;
      step(1);
      check("m0_pattern", {16'h0, pattern}, 32'h0003);
      check("m0_aw_count", 32'(aw_times.size() - s), 32'd3);
      if (aw_times.size() >= s + 3) begin
         check("m0_spacing1", 32'(aw_times[s+1] - aw_times[s]), 32'd4);
         check("m0_spacing2", 32'(aw_times[s+2] - aw_times[s+1]), 32'd4);
      end

      // Wrap FFFF -> 0000 via a static preload
      mode = 2'd3; static_pattern = 16'hFFFF; exp_pat = 16'hFFFF; exp_q.push_back(exp_pat);
      base = b_cnt; enable = 1'b1; wait_b(base + 1, 40); enable = 1'b0; step(1);
      check("static_pattern", {16'h0, pattern}, 32'hFFFF);
      mode = 2'd0; exp_pat = exp_pat + 16'd1; exp_q.push_back(exp_pat);
      base = b_cnt; enable = 1'b1; wait_b(base + 1, 40); enable = 1'b0; step(1);
      check("m0_wrap", {16'h0, pattern}, 32'h0000);

      // Bounce for 20 ticks
      mode = 2'd2; s = n8000;
      for (int i = 0; i < 16; i++) exp_q.push_back(16'h0001 << i);
      for (int i = 14; i >= 11; i--) exp_q.push_back(16'h0001 << i);
      exp_pat = 16'h0800;
      base = b_cnt; enable = 1'b1; wait_b(base + 20, 200); enable = 1'b0; step(1);
      check("m2_pattern", {16'h0, pattern}, {16'h0, exp_pat});
      check("m2_8000_once", 32'(n8000 - s), 32'd1);

      // AWREADY late: W retires first, AW stays up
      mode = 2'd0; period = 32'd15; aw_hold = 3; exp_pat = exp_pat + 16'd1; exp_q.push_back(exp_pat);
      base = b_cnt; enable = 1'b1; n = 0;
      while (!w_hs && n < 100) begin step(1); n++; end
      enable = 1'b0; step(1);
      check("stag1_wvalid", {31'h0, WVALID}, 0);
      check("stag1_awvalid", {31'h0, AWVALID}, 1);
      wait_b(base + 1, 40); step(5);
      check("stag1_one_b", 32'(b_cnt - base), 32'd1);
      // WREADY late: AW retires first
      aw_hold = 0; w_hold = 3; exp_pat = exp_pat + 16'd1; exp_q.push_back(exp_pat);
      base = b_cnt; enable = 1'b1; n = 0;
      while (!aw_hs && n < 100) begin step(1); n++; end
      enable = 1'b0; step(1);
      check("stag2_awvalid", {31'h0, AWVALID}, 0);
      check("stag2_wvalid", {31'h0, WVALID}, 1);
      wait_b(base + 1, 40); step(5);
      check("stag2_one_b", 32'(b_cnt - base), 32'd1);
      check("stag_pattern", {16'h0, pattern}, {16'h0, exp_pat});
      w_hold = 0;

      // SLVERR responses leave the pattern alone
      bresp_cfg = 2'b11;
      for (int i = 0; i < 3; i++) exp_q.push_back(exp_pat + 16'd1);
      base = b_cnt; enable = 1'b1; wait_b(base + 3, 100); enable = 1'b0; step(1);
      check("err3_count", {24'h0, err_count}, 32'd3);
      check("err3_pattern", {16'h0, pattern}, {16'h0, exp_pat});
      check("err3_overrun", {31'h0, overrun}, 0);
      period = 32'd0;
      for (int i = 0; i < 300; i++) exp_q.push_back(exp_pat + 16'd1);
      base = b_cnt; enable = 1'b1; wait_b(base + 300, 1500); enable = 1'b0; step(1);
      check("err_saturate", {24'h0, err_count}, 32'd255);
      check("err_sat_pattern", {16'h0, pattern}, {16'h0, exp_pat});
      check("overrun_set", {31'h0, overrun}, 1);
      check("q_drained", 32'(exp_q.size()), 32'd0);

      // period 0 with a slow B: ticks are dropped, no new AW before BREADY falls
      bresp_cfg = 2'b00; reset = 1'b1; step(2); reset = 1'b0; step(1);
      check("rst2_overrun", {31'h0, overrun}, 0);
      check("rst2_err", {24'h0, err_count}, 0);
      b_hold = 5; exp_pat = 16'h0001; exp_q.push_back(exp_pat);
      enable = 1'b1; n = 0;
      while (!BREADY && n < 50) begin step(1); n++; end
      check("bready_seen", {31'h0, BREADY}, 1);
      flag = 1'b0; n = 0;
      while (BREADY && n < 50) begin
         if (AWVALID) flag = 1'b1;
         step(1); n++;
      end
      enable = 1'b0;
      check("no_aw_in_resp", {31'h0, flag}, 0);
      check("overrun_p0", {31'h0, overrun}, 1);
      step(3);
      check("p0_pattern", {16'h0, pattern}, 32'h0001);
      b_hold = 0;

      // Reset during ADDR abandons the transaction
      mode = 2'd3; static_pattern = 16'hABCD; aw_hold = 10; w_hold = 10;
      enable = 1'b1; step(1);
      check("addr_awvalid", {31'h0, AWVALID}, 1);
      enable = 1'b0; reset = 1'b1; step(1);
      check("rstx_awvalid", {31'h0, AWVALID}, 0);
      check("rstx_wvalid", {31'h0, WVALID}, 0);
      check("rstx_bready", {31'h0, BREADY}, 0);
      check("rstx_busy", {31'h0, busy}, 0);
      check("rstx_pattern", {16'h0, pattern}, 32'h0000);
      reset = 1'b0; aw_hold = 0; w_hold = 0; step(2);

`ifdef LED_SEQ_READBACK_EN
      mode = 2'd0; period = 32'd15; rd_bad = 1'b1; exp_q.push_back(16'h0001);
      base = b_cnt; enable = 1'b1; wait_b(base + 1, 60); enable = 1'b0; step(4);
      check("rb_bad_mismatch", {24'h0, mismatch_count}, 32'd1);
      check("rb_pattern", {16'h0, pattern}, 32'h0001);
      rd_bad = 1'b0; exp_q.push_back(16'h0002);
      base = b_cnt; enable = 1'b1; wait_b(base + 1, 60); enable = 1'b0; step(4);
      check("rb_good_mismatch", {24'h0, mismatch_count}, 32'd1);
`endif

      step(5);
      check("q_final_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
